// File: rtl/mix_junction_sequencer.sv
// ---------------------------------------------------------------------------
// mix_junction_sequencer
//
// Valve sequencer for an N-inlet diffusion-mixer junction that feeds a
// serpentine channel. An accepted start latches the per-inlet dose counts and
// the flush count. Each inlet with a nonzero count is then opened in
// ascending index order for its count of cycles. Every executed dose is
// followed by SETTLE all-closed cycles. Finally the outlet valve is opened
// for flush_cnt cycles, and a one-cycle done pulse ends the run.
//
// Optional feature (macro MIX_ABORT_EN): adds the abort input and the
// aborted output. An abort sampled in DOSE or SETTLE closes the inlets and
// jumps to FLUSH, or to DONE when the flush count is zero.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (synchronous release)
//   start      in   run request, sampled only in IDLE
//   dose_cnt   in   N_INLETS x CNT_W per-inlet open times; inlet i at
//                   [i*CNT_W +: CNT_W]
//   flush_cnt  in   outlet open time in cycles
//   abort      in   (MIX_ABORT_EN only) abort the current run
//   valve_open out  inlet valve drives, one-hot or zero
//   out_valve  out  outlet/serpentine valve drive
//   busy       out  high in DOSE, SETTLE and FLUSH
//   ready      out  high only in IDLE
//   done       out  one-cycle completion pulse
//   aborted    out  (MIX_ABORT_EN only) qualifies done for an aborted run
//
// Handshake: start is accepted on a rising edge where start=1 and ready=1.
// Starts seen while ready=0 are dropped, not queued. done pulses for exactly
// one cycle, after which ready returns high on the following cycle.
// ---------------------------------------------------------------------------
module mix_junction_sequencer #(
    parameter int N_INLETS = 2,
    parameter int CNT_W    = 8,
    parameter int SETTLE   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N_INLETS*CNT_W-1:0] dose_cnt,
    input  logic [CNT_W-1:0]          flush_cnt,
`ifdef MIX_ABORT_EN
    input  logic                      abort,
    output logic                      aborted,
`endif
    output logic [N_INLETS-1:0]       valve_open,
    output logic                      out_valve,
    output logic                      busy,
    output logic                      ready,
    output logic                      done
);

    localparam int IDX_W = (N_INLETS > 1) ? $clog2(N_INLETS) : 1;
    localparam int SET_W = $clog2(SETTLE + 1);
    // One down-counter serves dose, settle and flush, so it must hold the
    // larger of the two ranges.
    localparam int CW    = (CNT_W > SET_W) ? CNT_W : SET_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DOSE   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]                state, nxt_state;
    logic [IDX_W-1:0]          idx, nxt_idx;
    logic [CW-1:0]             cnt, nxt_cnt;
    logic [N_INLETS*CNT_W-1:0] lat_dose;
    logic [CNT_W-1:0]          lat_flush;
    logic [IDX_W:0]            pick;
    logic                      accept;
`ifdef MIX_ABORT_EN
    logic                      abort_seen, nxt_abort;
`endif

    // Lowest inlet index >= from with a nonzero count. The result is
    // {found, index}. The loop runs downward so the last hit is the lowest.
    function automatic logic [IDX_W:0] find_next(
        input logic [N_INLETS*CNT_W-1:0] v,
        input int                        from
    );
        logic [IDX_W:0] r;
        r = '0;
        for (int j = N_INLETS - 1; j >= 0; j--) begin
            if (j >= from && v[j*CNT_W +: CNT_W] != '0) begin
                r = {1'b1, IDX_W'(j)};
            end
        end
        return r;
    endfunction

    assign accept = (state == S_IDLE) && start;

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        pick      = '0;
`ifdef MIX_ABORT_EN
        nxt_abort = abort_seen;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef MIX_ABORT_EN
                    nxt_abort = 1'b0;
`endif
                    // The live inputs are used here because the latch
                    // registers load on this same edge.
                    pick = find_next(dose_cnt, 0);
                    if (pick[IDX_W]) begin
                        nxt_state = S_DOSE;
                        nxt_idx   = pick[IDX_W-1:0];
                        nxt_cnt   = CW'(dose_cnt[pick[IDX_W-1:0]*CNT_W +: CNT_W]) - CW'(1);
                    end else if (flush_cnt != '0) begin
                        nxt_state = S_FLUSH;
                        nxt_cnt   = CW'(flush_cnt) - CW'(1);
                    end else begin
                        nxt_state = S_DONE;
                    end
                end
            end
            S_DOSE: begin
                if (cnt == '0) begin
                    nxt_state = S_SETTLE;
                    nxt_cnt   = CW'(SETTLE - 1);
                end else begin
                    nxt_cnt = cnt - CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    pick = find_next(lat_dose, int'(idx) + 1);
                    if (pick[IDX_W]) begin
                        nxt_state = S_DOSE;
                        nxt_idx   = pick[IDX_W-1:0];
                        nxt_cnt   = CW'(lat_dose[pick[IDX_W-1:0]*CNT_W +: CNT_W]) - CW'(1);
                    end else if (lat_flush != '0) begin
                        nxt_state = S_FLUSH;
                        nxt_cnt   = CW'(lat_flush) - CW'(1);
                    end else begin
                        nxt_state = S_DONE;
                    end
                end else begin
                    nxt_cnt = cnt - CW'(1);
                end
            end
            S_FLUSH: begin
                if (cnt == '0) begin
                    nxt_state = S_DONE;
                end else begin
                    nxt_cnt = cnt - CW'(1);
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
`ifdef MIX_ABORT_EN
        // This override comes after the case, so an abort wins over a dose
        // that ends on the same edge.
        if (abort && (state == S_DOSE || state == S_SETTLE)) begin
            nxt_abort = 1'b1;
            if (lat_flush != '0) begin
                nxt_state = S_FLUSH;
                nxt_cnt   = CW'(lat_flush) - CW'(1);
            end else begin
                nxt_state = S_DONE;
            end
        end
`endif
    end

    // The outputs are registered from the next-state values. Each valve
    // therefore changes on the same edge as the state, with no decode glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            lat_dose   <= '0;
            lat_flush  <= '0;
            valve_open <= '0;
            out_valve  <= 1'b0;
            busy       <= 1'b0;
            ready      <= 1'b1;
            done       <= 1'b0;
`ifdef MIX_ABORT_EN
            abort_seen <= 1'b0;
            aborted    <= 1'b0;
`endif
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            cnt   <= nxt_cnt;
            if (accept) begin
                lat_dose  <= dose_cnt;
                lat_flush <= flush_cnt;
            end
            valve_open <= (nxt_state == S_DOSE) ? (N_INLETS'(1) << nxt_idx) : '0;
            out_valve  <= (nxt_state == S_FLUSH);
            busy       <= (nxt_state == S_DOSE) || (nxt_state == S_SETTLE) ||
                          (nxt_state == S_FLUSH);
            ready      <= (nxt_state == S_IDLE);
            done       <= (nxt_state == S_DONE);
`ifdef MIX_ABORT_EN
            abort_seen <= nxt_abort;
            aborted    <= (nxt_state == S_DONE) && nxt_abort;
`endif
        end
    end

endmodule

// File: tb/tb_mix_junction_sequencer.sv
// Directed bench for mix_junction_sequencer. A reference trace of the output
// word {valve_open, out_valve, busy, ready, done} is queued for each run. The
// queue is drained one cycle at a time at the falling edge.
module tb_mix_junction_sequencer;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int ST = 4;
  localparam int W  = N + 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [N*CW-1:0] dose_cnt = '0;
  logic [CW-1:0]   flush_cnt = '0;
  logic [N-1:0]    valve_open;
  logic            out_valve, busy, ready, done;
`ifdef MIX_ABORT_EN
  logic            abort = 1'b0;
  logic            aborted;
`endif

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  mix_junction_sequencer #(.N_INLETS(N), .CNT_W(CW), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dose_cnt(dose_cnt),
    .flush_cnt(flush_cnt),
`ifdef MIX_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .valve_open(valve_open), .out_valve(out_valve), .busy(busy),
    .ready(ready), .done(done)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [W-1:0] obs();
    return {valve_open, out_valve, busy, ready, done};
  endfunction

  function automatic logic [W-1:0] word(input logic [N-1:0] vo, input logic ov,
                                        input logic b, input logic r, input logic d);
    return {vo, ov, b, r, d};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Reference model: expected per-cycle outputs from the first cycle after
  // acceptance through the DONE cycle.
  task automatic push_run(input logic [N*CW-1:0] d, input logic [CW-1:0] f);
    for (int i = 0; i < N; i++) begin
      logic [CW-1:0] di;
      logic [N-1:0]  oh;
      di = d[i*CW +: CW];
      oh = N'(1) << i;
      if (di != 0) begin
        for (int k = 0; k < int'(di); k++) exp_q.push_back(word(oh, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < ST; k++) exp_q.push_back(word('0, 1'b0, 1'b1, 1'b0, 1'b0));
      end
    end
    for (int k = 0; k < int'(f); k++) exp_q.push_back(word('0, 1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(word('0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  // Drives start at a falling edge and returns at the falling edge that
  // follows the accepting rising edge.
  task automatic launch(input logic [N*CW-1:0] d, input logic [CW-1:0] f, input logic hold);
    @(negedge clk);
    dose_cnt = d;
    flush_cnt = f;
    start = 1'b1;
    push_run(d, f);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      check(tag, obs(), exp_q.pop_front());
      @(negedge clk);
    end
  endtask

  localparam logic [W-1:0] IDLE_W = {{N{1'b0}}, 4'b0010};

  initial begin
    // reset block
    rst_n = 1'b0;
    #12;
    check("reset_state", obs(), IDLE_W);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_release", obs(), IDLE_W);

    // A reset mid-run closes the valves immediately and produces no done.
    launch({8'd0, 8'd0, 8'd3, 8'd5}, 8'd6, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("reset_run_dose", obs(), exp_q.pop_front());
      if (k < 2) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 check("reset_async_close", obs(), IDLE_W);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("reset_no_done", obs(), IDLE_W);
    end

    // Basic ratio {5,3}, flush 6: 23-cycle run. The inputs are scrambled
    // after acceptance and must not affect the run.
    launch({8'd0, 8'd0, 8'd3, 8'd5}, 8'd6, 1'b0);
    checks++;
    assert (exp_q.size() == 23) else begin
      failures++;
      $error("FAIL basic_len observed=%0d expected=23", exp_q.size());
    end
    dose_cnt = '1;
    flush_cnt = 8'd1;
    drain("basic_ratio");
    check("basic_idle", obs(), IDLE_W);

    // Skip zeros {0,2,0,1}, no flush: 12-cycle run.
    launch({8'd1, 8'd0, 8'd2, 8'd0}, 8'd0, 1'b0);
    drain("skip_zeros");
    check("skip_idle", obs(), IDLE_W);

    // Flush only.
    launch('0, 8'd3, 1'b0);
    drain("flush_only");
    check("flush_only_idle", obs(), IDLE_W);

    // All zero: done on the first cycle after acceptance.
    launch('0, 8'd0, 1'b0);
    drain("all_zero");
    check("all_zero_idle", obs(), IDLE_W);

    // Random short runs.
    for (int r = 0; r < 3; r++) begin
      logic [N*CW-1:0] rd;
      for (int i = 0; i < N; i++) rd[i*CW +: CW] = CW'($urandom_range(0, 4));
      launch(rd, CW'($urandom_range(0, 5)), 1'b0);
      drain("random_run");
      check("random_idle", obs(), IDLE_W);
    end

    // Max count with start held high: it is ignored during the run, and a
    // new run is accepted on the edge after returning to IDLE.
    launch({8'd0, 8'd0, 8'd0, 8'd255}, 8'd0, 1'b1);
    drain("max_count");
    check("hold_idle", obs(), IDLE_W);
    @(negedge clk);
    check("hold_restart", obs(), word(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0));
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("hold_reset_idle", obs(), IDLE_W);

`ifdef MIX_ABORT_EN
    // Abort during inlet0 dose cycle 2.
    launch({8'd0, 8'd0, 8'd3, 8'd5}, 8'd6, 1'b0);
    exp_q.delete();
    for (int k = 0; k < 2; k++) exp_q.push_back(word(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 6; k++) exp_q.push_back(word('0, 1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(word('0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 9; k++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("abort_run", obs(), e);
      checks++;
      assert (aborted === e[0]) else begin
        failures++;
        $error("FAIL aborted_flag observed=%b expected=%b", aborted, e[0]);
      end
      abort = (k == 1);
      @(negedge clk);
    end
    abort = 1'b0;
    check("abort_idle", obs(), IDLE_W);
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mix_junction_sequencer.md
Name: mix_junction_sequencer

Overview:
- Clocked valve sequencer for a parametrised N-inlet diffusion-mixer junction feeding a serpentine channel.
- Doses each inlet in turn for a programmed number of cycles, letting flow settle between doses.
- Then opens the outlet valve to flush the mixed fluid down the serpentine.
- Generalises the fixed two-inlet mixer-plus-serpentine junction to N inlets with ratioed dosing and a start/done handshake.

Parameters:
N_INLETS, 2, number of inlet valves (2..8)
CNT_W, 8, width of each dose/flush cycle count
SETTLE, 4, closed-valve cycles after every executed dose (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a mix run; sampled only in IDLE
dose_cnt  input  N_INLETS*CNT_W  per-inlet open time in cycles; inlet i in bits [i*CNT_W +: CNT_W]; latched on accepted start
flush_cnt  input  CNT_W  outlet open time in cycles; latched on accepted start
valve_open  output  N_INLETS  inlet valve drives, one-hot or zero
out_valve  output  1  outlet/serpentine valve drive
busy  output  1  high in DOSE, SETTLE, FLUSH
ready  output  1  high only in IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync release): state IDLE; valve_open=0, out_valve=0, busy=0, done=0, ready=1; latched counts cleared. Valves close immediately on rst_n low, including mid-run.
- States: IDLE, DOSE, SETTLE, FLUSH, DONE.
- IDLE: on an edge with start=1, latch dose_cnt/flush_cnt and select the lowest inlet index with nonzero count.
  - If one exists -> DOSE; else if flush_cnt!=0 -> FLUSH; else -> DONE.
- DOSE: valve_open[i] high for exactly dose_cnt[i] consecutive cycles, starting the cycle after the accepting edge (or after SETTLE). Then -> SETTLE.
- SETTLE: all valves closed for exactly SETTLE cycles. Then go to the next higher nonzero inlet (DOSE), else FLUSH if flush_cnt!=0, else DONE.
- Zero-count inlets are skipped entirely: no dose, no settle.
- FLUSH: out_valve high for exactly flush_cnt cycles, valve_open=0. Then -> DONE.
- DONE: one cycle; done=1, busy=0, ready=0; -> IDLE.
- Invariants:
  - Never more than one bit of valve_open high.
  - out_valve and valve_open never high together.
  - At least one all-closed cycle between any two valve-open intervals.
- start while not IDLE is ignored; no queueing. Input changes after acceptance have no effect on the current run.
- Counters are CNT_W wide; max dose/flush = 2^CNT_W-1 cycles, no wrap.
- Total run length = sum(nonzero doses) + SETTLE*(number of nonzero inlets) + flush_cnt + 1 (DONE) cycles.
- All outputs registered.

Optional Feature:
- Macro: MIX_ABORT_EN.
- When defined, adds ports abort (input, 1) and aborted (output, 1).
  - abort=1 sampled in DOSE or SETTLE closes inlets at the next edge and enters FLUSH with the latched flush_cnt (or DONE if zero).
  - abort in FLUSH, DONE or IDLE is ignored.
  - aborted is high alongside done at the end of an aborted run, 0 otherwise; reset value 0.
  - If abort and the natural end of DOSE coincide, abort wins.
- When not defined, both ports are absent and runs always complete.

Test Plan:
- Reset mid-run: N=2, dose={5,3}, flush=6, start; drop rst_n during inlet0 dose cycle 3 -> valve_open=0 immediately, ready=1 after release, no done pulse.
- Basic ratio: N=2, SETTLE=4, dose0=5, dose1=3, flush=6, start pulse -> valve_open=01 for 5 cycles, 4 closed, 10 for 3, 4 closed, out_valve 6 cycles, done pulse at run cycle 23.
- Skip zeros: N=4, dose={0,2,0,1}, flush=0 -> only inlets 1 and 3 open (2 and 1 cycles), no out_valve, done after 2+4+1+4+1=12 cycles.
- All zero: dose all 0, flush 0 -> done the cycle after acceptance, valves never open.
- Ignored start / max count: start held high through a run with dose0=255 (CNT_W=8) -> exactly 255 open cycles, one done, new run begins on the edge after returning to IDLE.
- Abort (MIX_ABORT_EN): dose={5,3}, flush=6, abort during inlet0 dose cycle 2 -> inlet closes at next edge, out_valve 6 cycles, done=1 with aborted=1.
